cpu_bus_unit: RTL

//  Parametrised multi-cycle memory sequencer between the CPU control FSM and the shared tristate bus.

---
 rtl/cpu_bus_unit_pkg.sv | 33 +++
 rtl/cpu_stack_ptr.sv | 33 +++
 rtl/cpu_bus_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_unit_pkg.sv
// Shared types for the CPU bus sequencer: request op codes, FSM states and op decode helpers.
// Used by cpu_bus_unit and by its testbench.
package cpu_bus_unit_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_FETCH = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_PUSH  = 3'd3,
        OP_POP   = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    function automatic logic op_is_reserved(input logic [OP_W-1:0] code);
        return code > 3'd4;
    endfunction

    function automatic logic op_is_read(input op_e op);
        return (op == OP_FETCH) || (op == OP_LOAD) || (op == OP_POP);
    endfunction

    function automatic logic op_is_write(input op_e op);
        return (op == OP_STORE) || (op == OP_PUSH);
    endfunction

endpackage

// File: rtl/cpu_stack_ptr.sv
// Stack pointer register for cpu_bus_unit: grows downward from SP_RESET, reports full/empty.
// The parent only issues push/pop on a completed, non-faulting stack access.
module cpu_stack_ptr #(
    parameter int unsigned        ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  SP_RESET = ADDR_W'('h07FF),
    parameter logic [ADDR_W-1:0]  SP_LIMIT = ADDR_W'('h0600)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    output logic [ADDR_W-1:0] sp,
    output logic              full,
    output logic              empty
);

    // SP points at the next free slot, so the last legal PUSH writes SP_LIMIT and leaves SP_LIMIT-1.
    localparam logic [ADDR_W-1:0] SP_FULL = SP_LIMIT - 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            sp <= SP_RESET;
        end else if (push) begin
            sp <= sp - 1'b1;
        end else if (pop) begin
            sp <= sp + 1'b1;
        end
    end

    assign full  = (sp == SP_FULL);
    assign empty = (sp == SP_RESET);

endmodule

// File: rtl/cpu_bus_unit.sv
// Multi-cycle memory sequencer (IDLE -> ACCESS -> RESP) owning PC and SP and the tristate bus.
// Optional bus watchdog enabled by defining CPU_BUS_TIMEOUT_EN.
module cpu_bus_unit
    import cpu_bus_unit_pkg::*;
#(
    parameter int unsigned        DATA_W   = 16,
    parameter int unsigned        ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  PC_RESET = '0,
    parameter logic [ADDR_W-1:0]  SP_RESET = ADDR_W'('h07FF),
    parameter logic [ADDR_W-1:0]  SP_LIMIT = ADDR_W'('h0600),
    parameter int unsigned        TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_value,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] address_bus,
    inout  wire  [DATA_W-1:0] data_bus,
    output logic              r,
    output logic              w,
    input  logic              bus_ready
);

    state_e            state, state_next;
    op_e               op_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic              accept;
    logic              fault;
    logic              access_done;
    logic              timeout;
    logic [ADDR_W-1:0] accept_addr;
    logic              sp_full, sp_empty;
    logic              sp_push, sp_pop;

    assign accept      = req_valid && (state == ST_IDLE);
    assign access_done = (state == ST_ACCESS) && bus_ready;

    // Faulting requests skip ACCESS entirely, so no strobe is raised and PC/SP stay put.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        fault = 1'b0;
        if (op_is_reserved(req_op)) begin
            fault = 1'b1;
        end else if ((req_op == OP_PUSH) && sp_full) begin
            fault = 1'b1;
        end else if ((req_op == OP_POP) && sp_empty) begin
            fault = 1'b1;
        end
    end

    always_comb begin
        accept_addr = req_addr;
        case (req_op)
            OP_FETCH: accept_addr = pc;
            OP_PUSH:  accept_addr = sp;
            OP_POP:   accept_addr = sp + 1'b1;
            default:  accept_addr = req_addr;
        endcase
    end

`ifdef CPU_BUS_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_cnt;

    // Counts completed wait cycles; the strobe is dropped at the end of the TIMEOUT-th one.
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            wait_cnt <= '0;
        end else if ((state == ST_ACCESS) && !bus_ready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout = (state == ST_ACCESS) && !bus_ready && (wait_cnt == WAIT_W'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (req_valid) state_next = fault ? ST_RESP : ST_ACCESS;
            ST_ACCESS: if (bus_ready || timeout) state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q        <= OP_FETCH;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            address_bus <= '0;
            rsp_data    <= '0;
            pc          <= PC_RESET;
        end else begin
            if (accept) begin
                op_q        <= op_e'(req_op);
                wdata_q     <= req_wdata;
                err_q       <= fault;
                address_bus <= accept_addr;
            end else if (timeout) begin
                err_q <= 1'b1;
            end

            if (access_done && op_is_read(op_q)) begin
                rsp_data <= data_bus;
            end

            // An external jump overrides the fetch increment landing on the same edge.
            if (pc_load) begin
                pc <= pc_value;
            end else if (access_done && (op_q == OP_FETCH)) begin
                pc <= pc + 1'b1;
            end
        end
    end

    assign sp_push = access_done && (op_q == OP_PUSH);
    assign sp_pop  = access_done && (op_q == OP_POP);

    cpu_stack_ptr #(
        .ADDR_W   (ADDR_W),
        .SP_RESET (SP_RESET),
        .SP_LIMIT (SP_LIMIT)
    ) u_stack_ptr (
        .clk   (clk),
        .reset (reset),
        .push  (sp_push),
        .pop   (sp_pop),
        .sp    (sp),
        .full  (sp_full),
        .empty (sp_empty)
    );

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign r         = (state == ST_ACCESS) && op_is_read(op_q);
    assign w         = (state == ST_ACCESS) && op_is_write(op_q);
    assign data_bus  = w ? wdata_q : {DATA_W{1'bz}};

endmodule
